// File: rtl/sddr_rd_capture_pkg.sv
// Shared configuration, capture-state encoding and response entry type for
// the DDR3 read-data capture stage.
package sddr_pkg;

  localparam int DATA_BITS     = 16;
  localparam int BURST_LENGTH  = 8;
  localparam int MAX_LATENCY   = 31;
  localparam int TAG_BITS      = 4;

  localparam int BEATS         = BURST_LENGTH / 2;
  localparam int BEAT_BITS     = 2 * DATA_BITS;
  localparam int BURST_BITS    = BURST_LENGTH * DATA_BITS;
  localparam int LAT_BITS      = $clog2(MAX_LATENCY + 1);
  localparam int BEAT_CNT_BITS = $clog2(BEATS);

  typedef enum logic [0:0] {
    CAP_IDLE = 1'b0,
    CAP_BEAT = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [BURST_BITS-1:0] data;
    logic [TAG_BITS-1:0]   tag;
  } rsp_entry_t;

  // A latency of 0 cannot be honoured by the line, so it behaves as 1.
  function automatic logic [LAT_BITS-1:0] eff_latency(input logic [LAT_BITS-1:0] cfg);
    if (cfg == '0) begin
      return LAT_BITS'(1);
    end else if (int'(cfg) > MAX_LATENCY) begin
      return LAT_BITS'(MAX_LATENCY);
    end else begin
      return cfg;
    end
  endfunction

endpackage

// File: rtl/sddr_rd_capture_if.sv
// Response port from the read-capture stage toward the data client.
interface sddr_rd_capture_if;
  import sddr_pkg::*;

  // data_rsp_valid stays high and data/tag stay stable until the cycle in which
  // data_rsp_ready is also high; that cycle transfers one burst. Ready may be
  // asserted without valid and has no effect then.
  logic                  data_rsp_valid;
  logic                  data_rsp_ready;
  logic [BURST_BITS-1:0] data_rsp_data;
  logic [TAG_BITS-1:0]   data_rsp_tag;

  modport master (
    output data_rsp_valid,
    output data_rsp_data,
    output data_rsp_tag,
    input  data_rsp_ready
  );

  modport slave (
    input  data_rsp_valid,
    input  data_rsp_data,
    input  data_rsp_tag,
    output data_rsp_ready
  );

endinterface

// File: rtl/sddr_rsp_fifo.sv
// Two-entry response buffer; simultaneous push and pop is legal at any fill
// level, a push into a full buffer without a pop is dropped and flagged.
module sddr_rsp_fifo
  import sddr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  rsp_entry_t push_entry_i,
  input  logic       pop_i,
  output rsp_entry_t head_o,
  output logic       empty_o,
  output logic       overflow_o
);

  rsp_entry_t mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       full;
  logic       pop_ok;
  logic       push_ok;

  assign full    = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full | pop_ok);

  assign overflow_o = push_i & full & ~pop_ok;
  assign head_o     = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/sddr_rd_capture.sv
// DDR3 read-data capture: delays each READ by the configured latency, gathers
// the double-width beats of the burst and hands the burst word to the client.
module sddr_rd_capture
  import sddr_pkg::*;
(
  input  logic                 cpu_clock_i,
  input  logic                 reset_n_i,
  input  logic [LAT_BITS-1:0]  cfg_read_latency_i,
  input  logic                 rd_issue_i,
  input  logic [TAG_BITS-1:0]  rd_tag_i,
  input  logic                 ddr3_dq_enable_i,
  input  logic [BEAT_BITS-1:0] ddr3_dq_i,
  sddr_rd_capture_if.master    rsp,
  output logic                 busy_o,
  output logic                 err_collision_o,
  output logic                 err_overflow_o,
  output logic                 err_dq_conflict_o,
  output cap_state_e           dbg_cap_state_o
);

  // ---------------- latency line ----------------
  logic [MAX_LATENCY-1:0] slot_vld_q, slot_vld_d;
  logic [TAG_BITS-1:0]    slot_tag_q [MAX_LATENCY];
  logic [TAG_BITS-1:0]    slot_tag_d [MAX_LATENCY];
  logic [LAT_BITS-1:0]    slot_idx;
  logic                   issue_collide;

  assign slot_idx = eff_latency(cfg_read_latency_i) - LAT_BITS'(1);

  // The issue targets its slot after this cycle's shift, so a collision means
  // two reads would need their first beat on the same clock.
  always_comb begin
    slot_vld_d    = slot_vld_q >> 1;
    issue_collide = 1'b0;
    for (int i = 0; i < MAX_LATENCY - 1; i++) begin
      slot_tag_d[i] = slot_tag_q[i+1];
    end
    slot_tag_d[MAX_LATENCY-1] = '0;
    if (rd_issue_i) begin
      if (slot_vld_d[slot_idx]) begin
        issue_collide = 1'b1;
      end else begin
        slot_vld_d[slot_idx] = 1'b1;
        slot_tag_d[slot_idx] = rd_tag_i;
      end
    end
  end

  // ---------------- capture FSM ----------------
  cap_state_e                 state_q, state_d;
  logic [BEAT_CNT_BITS-1:0]   beat_q, beat_d;
  logic [BURST_BITS-1:0]      data_q, data_d;
  logic [TAG_BITS-1:0]        tag_q, tag_d;
  logic                       push;
  logic                       cap_collide;
  logic                       capturing;

  // Beat 0 is taken on the edge that ends the cycle in which slot 0 is valid,
  // so CAP_BEAT always captures beats 1..BEATS-1. A slot-0 arrival while in
  // CAP_BEAT would need the same clock edge as a beat already owed.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    data_d      = data_q;
    tag_d       = tag_q;
    push        = 1'b0;
    cap_collide = 1'b0;
    capturing   = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (slot_vld_q[0]) begin
          capturing                = 1'b1;
          data_d                   = '0;
          data_d[0 +: BEAT_BITS]   = ddr3_dq_i;
          tag_d                    = slot_tag_q[0];
          beat_d                   = BEAT_CNT_BITS'(1);
          state_d                  = CAP_BEAT;
        end
      end
      CAP_BEAT: begin
        capturing                            = 1'b1;
        cap_collide                          = slot_vld_q[0];
        data_d[beat_q*BEAT_BITS +: BEAT_BITS] = ddr3_dq_i;
        if (beat_q == BEAT_CNT_BITS'(BEATS - 1)) begin
          push    = 1'b1;
          beat_d  = '0;
          state_d = CAP_IDLE;
        end else begin
          beat_d = beat_q + BEAT_CNT_BITS'(1);
        end
      end
      default: begin
        state_d = CAP_IDLE;
      end
    endcase
  end

  // ---------------- response buffer ----------------
  rsp_entry_t push_entry;
  rsp_entry_t fifo_head;
  logic       fifo_empty;
  logic       fifo_overflow;

  assign push_entry.data = data_d;
  assign push_entry.tag  = tag_q;

  sddr_rsp_fifo u_rsp_fifo (
    .clk_i        (cpu_clock_i),
    .rst_ni       (reset_n_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (rsp.data_rsp_ready),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty),
    .overflow_o   (fifo_overflow)
  );

  assign rsp.data_rsp_valid = ~fifo_empty;
  assign rsp.data_rsp_data  = fifo_head.data;
  assign rsp.data_rsp_tag   = fifo_head.tag;

  // ---------------- state and sticky errors ----------------
  logic err_collision_q, err_overflow_q, err_dq_conflict_q;

  always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slot_vld_q <= '0;
      for (int i = 0; i < MAX_LATENCY; i++) begin
        slot_tag_q[i] <= '0;
      end
      state_q           <= CAP_IDLE;
      beat_q            <= '0;
      data_q            <= '0;
      tag_q             <= '0;
      err_collision_q   <= 1'b0;
      err_overflow_q    <= 1'b0;
      err_dq_conflict_q <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      for (int i = 0; i < MAX_LATENCY; i++) begin
        slot_tag_q[i] <= slot_tag_d[i];
      end
      state_q           <= state_d;
      beat_q            <= beat_d;
      data_q            <= data_d;
      tag_q             <= tag_d;
      err_collision_q   <= err_collision_q | issue_collide | cap_collide;
      err_overflow_q    <= err_overflow_q | fifo_overflow;
      err_dq_conflict_q <= err_dq_conflict_q | (capturing & ddr3_dq_enable_i);
    end
  end

  assign busy_o            = (|slot_vld_q) | (state_q != CAP_IDLE) | ~fifo_empty;
  assign err_collision_o   = err_collision_q;
  assign err_overflow_o    = err_overflow_q;
  assign err_dq_conflict_o = err_dq_conflict_q;
  assign dbg_cap_state_o   = state_q;

endmodule
